// File: rtl/key_adjust_ctrl.sv
// Pushbutton front-end for the time/alarm adjust path: sync + debounce of three
// active-low keys, adjust field select, and inc/dec pulses with hold-to-repeat.
module key_adjust_ctrl #(
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RPT_DELAY  = 25_000_000,
    parameter int unsigned RPT_PERIOD = 5_000_000,
    parameter int unsigned NUM_FIELDS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw17,
    input  logic       key1_n,
    input  logic       key2_n,
    input  logic       key3_n,
    output logic [1:0] adjust,
    output logic       key2,
    output logic       key3
);

    localparam int unsigned NK    = 3;
    localparam int unsigned DB_W  = $clog2(DB_CYCLES);
    localparam int unsigned TMR_W = 25;
    localparam int unsigned ADJ_W = 2;

    typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t;

    logic [NK-1:0]           sync1;
    logic [NK-1:0]           sync2;
    logic [NK-1:0]           stable;
    logic [NK-1:0]           stable_d;
    logic [NK-1:0][DB_W-1:0] db_cnt;
    logic [NK-1:0]           pressed;
    logic [NK-1:0]           press_edge;
    logic                    sw17_d;

    assign pressed    = ~sync2;
    assign press_edge = stable & ~stable_d;

    // Two-flop sync and per-key debounce; index 0/1/2 = key1/key2/key3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '1;
            sync2    <= '1;
            stable   <= '0;
            stable_d <= '0;
            db_cnt   <= '0;
        end else begin
            sync1    <= {key3_n, key2_n, key1_n};
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < NK; i++) begin
                if (pressed[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    stable[i] <= pressed[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Field select: cleared when adjust mode is entered, advanced by key1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adjust <= '0;
            sw17_d <= 1'b0;
        end else begin
            sw17_d <= sw17;
            if (sw17 && !sw17_d) begin
                adjust <= '0;
            end else if (sw17 && press_edge[0]) begin
                adjust <= (adjust == ADJ_W'(NUM_FIELDS - 1)) ? '0 : adjust + ADJ_W'(1);
            end
        end
    end

    rpt_state_t       state     [2];
    rpt_state_t       state_nxt [2];
    logic [TMR_W-1:0] tmr       [2];
    logic [TMR_W-1:0] tmr_nxt   [2];
    logic [1:0]       pulse_nxt;
    logic [1:0]       go;
    logic [1:0]       held;

    // Index 0 = increment (key2), 1 = decrement (key3); key2 wins a tie.
    assign held  = stable[2:1];
    assign go[0] = press_edge[1] && (state[1] == IDLE);
    assign go[1] = press_edge[2] && (state[0] == IDLE) && !go[0];

    always_comb begin
        pulse_nxt = '0;
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            tmr_nxt[i]   = tmr[i];
            if (!sw17 || !held[i]) begin
                state_nxt[i] = IDLE;
                tmr_nxt[i]   = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (go[i]) begin
                            state_nxt[i] = HOLD;
                            tmr_nxt[i]   = TMR_W'(RPT_DELAY - 1);
                            pulse_nxt[i] = 1'b1;
                        end
                    end
                    HOLD, RPT: begin
                        if (tmr[i] == '0) begin
                            state_nxt[i] = RPT;
                            tmr_nxt[i]   = TMR_W'(RPT_PERIOD - 1);
                            pulse_nxt[i] = 1'b1;
                        end else begin
                            tmr_nxt[i] = tmr[i] - TMR_W'(1);
                        end
                    end
                    default: begin
                        state_nxt[i] = IDLE;
                        tmr_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                tmr[i]   <= '0;
            end
            key2 <= 1'b0;
            key3 <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                tmr[i]   <= tmr_nxt[i];
            end
            key2 <= pulse_nxt[0];
            key3 <= pulse_nxt[1];
        end
    end

endmodule

// File: tb/tb_key_adjust_ctrl.sv
// Scoreboard bench for key_adjust_ctrl: stimulus queues expected pulses/adjust
// changes with their cycle stamps, a negedge monitor pops and compares them.
module tb_key_adjust_ctrl;

    localparam int unsigned DB  = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 5;
    localparam int unsigned LAT = DB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw17;
    logic       key1_n;
    logic       key2_n;
    logic       key3_n;
    logic [1:0] adjust;
    logic       key2;
    logic       key3;

    key_adjust_ctrl #(
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP),
        .NUM_FIELDS(3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw17  (sw17),
        .key1_n(key1_n),
        .key2_n(key2_n),
        .key3_n(key3_n),
        .adjust(adjust),
        .key2  (key2),
        .key3  (key3)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  val;
    } ev_t;

    ev_t        pq[$];
    ev_t        aq[$];
    int         checks   = 0;
    int         failures = 0;
    int         n_key2   = 0;
    int         n_key3   = 0;
    logic [1:0] adj_prev = 2'd0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic push_ev(input bit is_adj, input int unsigned c, input logic [1:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        if (is_adj) aq.push_back(e);
        else        pq.push_back(e);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            1:       key1_n = v;
            2:       key2_n = v;
            default: key3_n = v;
        endcase
    endtask

    // Press key k for 'hold' cycles; queue the pulse train (or the adjust step).
    task automatic press(input int k, input int hold, input bit expect_on, input logic [1:0] adj_val);
        int unsigned n;
        int unsigned p;
        logic [1:0]  kind;
        n = cyc;
        set_key(k, 1'b0);
        if (expect_on) begin
            if (k == 1) begin
                push_ev(1'b1, n + LAT, adj_val);
            end else begin
                kind = (k == 2) ? 2'b01 : 2'b10;
                push_ev(1'b0, n + LAT, kind);
                p = n + LAT + RD;
                while (p <= n + hold + LAT - 1) begin
                    push_ev(1'b0, p, kind);
                    p += RP;
                end
            end
        end
        tick(hold);
        set_key(k, 1'b1);
        tick(12);
    endtask

    // Monitor: every pulse or adjust change must match the head of its queue.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            checks++;
            if (key2 || key3 || adjust != 2'd0) begin
                failures++;
                $display("FAIL reset_outputs actual=%b%b/%0d expected=00/0", key2, key3, adjust);
            end
        end else begin
            if (key2) n_key2++;
            if (key3) n_key3++;
            if (key2 || key3) begin
                checks++;
                if (pq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cyc=%0d actual=%b%b expected=none", cyc, key3, key2);
                end else begin
                    e = pq.pop_front();
                    if (e.cyc != cyc || e.val != {key3, key2}) begin
                        failures++;
                        $display("FAIL pulse actual=cyc%0d/%b expected=cyc%0d/%b", cyc, {key3, key2}, e.cyc, e.val);
                    end
                end
            end
            if (adjust != adj_prev) begin
                checks++;
                if (aq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_adjust cyc=%0d actual=%0d expected=%0d", cyc, adjust, adj_prev);
                end else begin
                    e = aq.pop_front();
                    if (e.cyc != cyc || e.val != adjust) begin
                        failures++;
                        $display("FAIL adjust actual=cyc%0d/%0d expected=cyc%0d/%0d", cyc, adjust, e.cyc, e.val);
                    end
                end
            end
        end
        adj_prev = adjust;
    end

    initial begin
        int unsigned n;
        int unsigned r;
        int unsigned rel;
        int unsigned p;
        int          c2;
        int          c3;

        rst    = 1'b1;
        sw17   = 1'b0;
        key1_n = 1'b1;
        key2_n = 1'b1;
        key3_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_adjust", int'(adjust), 0);
        check("reset_key2", int'(key2), 0);
        check("reset_key3", int'(key3), 0);
        sw17 = 1'b1;
        tick(3);

        // 1: 2-cycle bounce is rejected, then one pulse LAT after the settle.
        for (int i = 0; i < 10; i++) begin
            key2_n = (i % 2 == 1);
            tick(2);
        end
        c2 = n_key2;
        press(2, 10, 1'b1, 2'd0);
        check("t1_key2_count", n_key2 - c2, 1);
        check("t1_key3_count", n_key3, 0);

        // 2: hold-to-repeat, nine pulses (t0, +20, +25 ... +55).
        c2 = n_key2;
        press(2, 58, 1'b1, 2'd0);
        check("t2_key2_count", n_key2 - c2, 9);

        // 3: field select wraps, and re-entering adjust mode clears it.
        press(1, 10, 1'b1, 2'd1);
        press(1, 10, 1'b1, 2'd2);
        press(1, 10, 1'b1, 2'd0);
        press(1, 10, 1'b1, 2'd1);
        check("t3_adjust_before", int'(adjust), 1);
        sw17 = 1'b0;
        tick(3);
        push_ev(1'b1, cyc + 1, 2'd0);
        sw17 = 1'b1;
        tick(3);
        check("t3_adjust_cleared", int'(adjust), 0);
        press(1, 10, 1'b1, 2'd1);

        // 4: adjust disabled, nothing reacts.
        sw17 = 1'b0;
        tick(2);
        c2 = n_key2;
        c3 = n_key3;
        press(2, 30, 1'b0, 2'd0);
        press(3, 30, 1'b0, 2'd0);
        press(1, 15, 1'b0, 2'd0);
        check("t4_key2_count", n_key2 - c2, 0);
        check("t4_key3_count", n_key3 - c3, 0);
        check("t4_adjust_hold", int'(adjust), 1);
        push_ev(1'b1, cyc + 1, 2'd0);
        sw17 = 1'b1;
        tick(3);

        // 5: simultaneous press, key2 wins; key3 needs a fresh press.
        c2 = n_key2;
        c3 = n_key3;
        n = cyc;
        key2_n = 1'b0;
        key3_n = 1'b0;
        push_ev(1'b0, n + LAT, 2'b01);
        tick(12);
        key2_n = 1'b1;
        tick(30);
        check("t5_key3_blocked", n_key3 - c3, 0);
        key3_n = 1'b1;
        tick(12);
        press(3, 10, 1'b1, 2'd0);
        check("t5_key2_count", n_key2 - c2, 1);
        check("t5_key3_count", n_key3 - c3, 1);

        // 6: reset during repeat; held key re-debounces after release.
        c2 = n_key2;
        n = cyc;
        key2_n = 1'b0;
        push_ev(1'b0, n + LAT, 2'b01);
        push_ev(1'b0, n + LAT + RD, 2'b01);
        push_ev(1'b0, n + LAT + RD + RP, 2'b01);
        tick(LAT + RD + RP + 2);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        r = cyc;
        rel = r + 40;
        push_ev(1'b0, r + LAT, 2'b01);
        p = r + LAT + RD;
        while (p <= rel + LAT - 1) begin
            push_ev(1'b0, p, 2'b01);
            p += RP;
        end
        tick(40);
        key2_n = 1'b1;
        tick(15);
        check("t6_key2_count", n_key2 - c2, 8);

        tick(5);
        check("pulse_queue_empty", pq.size(), 0);
        check("adjust_queue_empty", aq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
